// File: rtl/custom_axi_ip_pkg.sv
// Shared types and constants for the custom_axi_ip register front-end:
// IP status encoding, AXI response codes, register offsets and CTRL/STATUS bit positions.
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        ERROR = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    // Byte offsets of the four 32-bit registers
    localparam logic [3:0] CTRL_OFS     = 4'h0;
    localparam logic [3:0] DATA_IN_OFS  = 4'h4;
    localparam logic [3:0] DATA_OUT_OFS = 4'h8;
    localparam logic [3:0] STATUS_OFS   = 4'hC;

    // CTRL register bits
    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_IE_BIT      = 1;
    localparam int CTRL_IRQ_CLR_BIT = 2;

    // STATUS register bits ([1:0] carry status_e)
    localparam int STATUS_EN_BIT   = 2;
    localparam int STATUS_PEND_BIT = 8;

endpackage

// File: rtl/axi_lite_wr_join.sv
// Joins the AXI4-Lite AW and W channels: each is captured independently and a
// single commit strobe is produced once both halves are available. The commit
// happens on the edge where the second half arrives (or both arrive together),
// and address/data/strobe are presented from the held copy or the live channel.
module axi_lite_wr_join
    import custom_axi_ip_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    busy_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic                    commit_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH/8-1:0] strb_o
);

    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q,  w_held_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic [DATA_WIDTH/8-1:0] strb_q,    strb_d;
    logic                    aw_hs;
    logic                    w_hs;

    // A channel stops accepting once captured, and both stop while the response is pending
    assign awready_o = ~aw_held_q & ~busy_i;
    assign wready_o  = ~w_held_q  & ~busy_i;
    assign aw_hs     = awvalid_i & awready_o;
    assign w_hs      = wvalid_i  & wready_o;

    assign commit_o = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign addr_o   = aw_held_q ? addr_q : awaddr_i;
    assign data_o   = w_held_q  ? data_q : wdata_i;
    assign strb_o   = w_held_q  ? strb_q : wstrb_i;

    // Capture each channel on its handshake; release both holds on commit
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            addr_d    = awaddr_i;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            data_d   = wdata_i;
            strb_d   = wstrb_i;
        end
        if (commit_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
    end

    // Capture state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

endmodule

// File: rtl/axi_lite_ipreg_slave.sv
// AXI4-Lite register front-end for custom_axi_ip: holds DATA_IN, pulses the
// IP enable on START, and reads back the IP data, enable and status.
// Optional interrupt logic (irq_o, CTRL.IE, CTRL.IRQ_CLR, STATUS.PEND) is
// built when CUSTOM_AXI_IP_IRQ_EN is defined.
module axi_lite_ipreg_slave
    import custom_axi_ip_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
    input  logic                    s_awvalid_i,
    output logic                    s_awready_o,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
    input  logic                    s_wvalid_i,
    output logic                    s_wready_o,
    output logic [1:0]              s_bresp_o,
    output logic                    s_bvalid_o,
    input  logic                    s_bready_i,
    input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
    input  logic                    s_arvalid_i,
    output logic                    s_arready_o,
    output logic [DATA_WIDTH-1:0]   s_rdata_o,
    output logic [1:0]              s_rresp_o,
    output logic                    s_rvalid_o,
    input  logic                    s_rready_i,
    output logic [DATA_WIDTH-1:0]   ipreg_data_o,
    output logic                    enable_o,
    input  logic [DATA_WIDTH-1:0]   ipreg_data_i,
    input  logic                    enable_i,
`ifdef CUSTOM_AXI_IP_IRQ_EN
    output logic                    irq_o,
`endif
    input  status_e                 status_i
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("axi_lite_ipreg_slave: DATA_WIDTH must be 32");
    end

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    // ---------------- write path ----------------
    wstate_e                 wstate_q, wstate_d;
    logic                    bvalid_q, bvalid_d;
    resp_e                   bresp_q,  bresp_d;
    logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
    logic                    enable_q, enable_d;
    logic                    wr_commit;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic [DATA_WIDTH-1:0]   byte_mask;
    logic                    wr_start;
    logic                    wr_err;

`ifdef CUSTOM_AXI_IP_IRQ_EN
    logic    ie_q, ie_d;
    logic    pending_q, pending_d;
    logic    irq_q, irq_d;
    status_e status_prev_q;
    logic    irq_set;
    logic    irq_clr;
`endif

    axi_lite_wr_join #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_join (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .busy_i    (wstate_q == W_RESP),
        .awaddr_i  (s_awaddr_i),
        .awvalid_i (s_awvalid_i),
        .awready_o (s_awready_o),
        .wdata_i   (s_wdata_i),
        .wstrb_i   (s_wstrb_i),
        .wvalid_i  (s_wvalid_i),
        .wready_o  (s_wready_o),
        .commit_o  (wr_commit),
        .addr_o    (wr_addr),
        .data_o    (wr_data),
        .strb_o    (wr_strb)
    );

    // Expand write strobes into a per-bit mask for DATA_IN
    for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_byte_mask
        assign byte_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end

    // START is only meaningful when its byte lane is enabled
    assign wr_start = wr_data[CTRL_START_BIT] & wr_strb[0];

    // Write commit decode, response generation and B-channel handshake
    always_comb begin
        wstate_d  = wstate_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        data_in_d = data_in_q;
        enable_d  = 1'b0;
        wr_err    = 1'b0;
`ifdef CUSTOM_AXI_IP_IRQ_EN
        ie_d      = ie_q;
        irq_clr   = 1'b0;
`endif
        case (wstate_q)
            W_IDLE: begin
                if (wr_commit) begin
                    wstate_d = W_RESP;
                    bvalid_d = 1'b1;
                    // Full-address compare also rejects unaligned and unmapped offsets
                    if (wr_addr == ADDR_WIDTH'(CTRL_OFS)) begin
                        if (wr_start && (status_i != IDLE)) begin
                            wr_err = 1'b1;
                        end else begin
                            enable_d = wr_start;
`ifdef CUSTOM_AXI_IP_IRQ_EN
                            if (wr_strb[0]) begin
                                ie_d    = wr_data[CTRL_IE_BIT];
                                irq_clr = wr_data[CTRL_IRQ_CLR_BIT];
                            end
`endif
                        end
                    end else if (wr_addr == ADDR_WIDTH'(DATA_IN_OFS)) begin
                        data_in_d = (data_in_q & ~byte_mask) | (wr_data & byte_mask);
                    end else begin
                        wr_err = 1'b1;
                    end
                    bresp_d = wr_err ? SLVERR : OKAY;
                end
            end
            W_RESP: begin
                if (s_bready_i) begin
                    wstate_d = W_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write-side state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            data_in_q <= '0;
            enable_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            data_in_q <= data_in_d;
            enable_q  <= enable_d;
        end
    end

    assign s_bvalid_o   = bvalid_q;
    assign s_bresp_o    = bresp_q;
    assign ipreg_data_o = data_in_q;
    assign enable_o     = enable_q;

`ifdef CUSTOM_AXI_IP_IRQ_EN
    // Pending flag: set on entry into DONE, cleared by CTRL.IRQ_CLR; set wins
    always_comb begin
        irq_set   = (status_i == DONE) && (status_prev_q != DONE);
        pending_d = irq_set | (pending_q & ~irq_clr);
        irq_d     = pending_d & ie_d;
    end

    // Interrupt state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ie_q          <= 1'b0;
            pending_q     <= 1'b0;
            irq_q         <= 1'b0;
            status_prev_q <= IDLE;
        end else begin
            ie_q          <= ie_d;
            pending_q     <= pending_d;
            irq_q         <= irq_d;
            status_prev_q <= status_i;
        end
    end

    assign irq_o = irq_q;
`endif

    // ---------------- read path ----------------
    rstate_e               rstate_q, rstate_d;
    logic                  rvalid_q, rvalid_d;
    resp_e                 rresp_q,  rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic [DATA_WIDTH-1:0] ctrl_word;
    logic [DATA_WIDTH-1:0] status_word;

    // Readback images of CTRL and STATUS
    always_comb begin
        ctrl_word   = '0;
        status_word = '0;
        status_word[1:0]           = status_i;
        status_word[STATUS_EN_BIT] = enable_i;
`ifdef CUSTOM_AXI_IP_IRQ_EN
        ctrl_word[CTRL_IE_BIT]       = ie_q;
        status_word[STATUS_PEND_BIT] = pending_q;
`endif
    end

    // AR decode sampled at the handshake edge; R held until rready
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (s_arvalid_i) begin
                    rstate_d = R_DATA;
                    rvalid_d = 1'b1;
                    rresp_d  = OKAY;
                    rdata_d  = '0;
                    if (s_araddr_i == ADDR_WIDTH'(CTRL_OFS)) begin
                        rdata_d = ctrl_word;
                    end else if (s_araddr_i == ADDR_WIDTH'(DATA_IN_OFS)) begin
                        rdata_d = data_in_q;
                    end else if (s_araddr_i == ADDR_WIDTH'(DATA_OUT_OFS)) begin
                        rdata_d = ipreg_data_i;
                    end else if (s_araddr_i == ADDR_WIDTH'(STATUS_OFS)) begin
                        rdata_d = status_word;
                    end else begin
                        rresp_d = SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (s_rready_i) begin
                    rstate_d = R_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read-side state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign s_arready_o = (rstate_q == R_IDLE);
    assign s_rvalid_o  = rvalid_q;
    assign s_rresp_o   = rresp_q;
    assign s_rdata_o   = rdata_q;

endmodule
